// File: rtl/deadlock_monitor_pkg.sv
// Shared constants and helpers for the kernel deadlock monitors.
package deadlock_monitor_pkg;

  localparam int unsigned DFLT_N_AXIS          = 3;
  localparam int unsigned DFLT_N_INST          = 1;
  localparam int unsigned DFLT_BLOCK_THRESHOLD = 4;

  // Counter must hold 0..threshold inclusive.
  function automatic int unsigned cnt_width(input int unsigned threshold);
    return (threshold < 1) ? 1 : $clog2(threshold + 1);
  endfunction

endpackage

// File: rtl/stall_persistence_counter.sv
// Saturating count of consecutive stalled cycles; hit flags the cycle the count reaches THRESHOLD.
module stall_persistence_counter
  import deadlock_monitor_pkg::*;
#(
  parameter int unsigned THRESHOLD = DFLT_BLOCK_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  output logic hit
);

  localparam int unsigned   CW  = cnt_width(THRESHOLD);
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (stall) begin
      cnt_next = (cnt == THR) ? cnt : cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign hit = (cnt_next == THR);

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Per-kernel deadlock detector: raises block after a sustained stall.
// Define DEADLOCK_MONITOR_STICKY_EN to hold block high until reset.
module deadlock_idx0_monitor
  import deadlock_monitor_pkg::*;
#(
  parameter int unsigned N_AXIS          = DFLT_N_AXIS,
  parameter int unsigned N_INST          = DFLT_N_INST,
  parameter int unsigned BLOCK_THRESHOLD = DFLT_BLOCK_THRESHOLD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block
);

  logic stall_now;
  logic hit;
  logic block_next;

  // An instance that is blocked but also idle is not stalling the kernel.
  assign stall_now = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs));

  stall_persistence_counter #(
    .THRESHOLD (BLOCK_THRESHOLD)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .stall (stall_now),
    .hit   (hit)
  );

  always_comb begin
    block_next = hit;
`ifdef DEADLOCK_MONITOR_STICKY_EN
    block_next = block | hit;
`else
    block_next = hit;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block <= 1'b0;
    end else begin
      block <= block_next;
    end
  end

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed bench for deadlock_idx0_monitor with default parameters (threshold 4).
module tb_deadlock_idx0_monitor;

`ifdef DEADLOCK_MONITOR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       kernel_monitor_clock;
  logic       reset;
  logic [2:0] axis_block_sigs;
  logic [0:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       block;

  int unsigned passed;
  int unsigned total;

  deadlock_idx0_monitor #(
    .N_AXIS          (3),
    .N_INST          (1),
    .BLOCK_THRESHOLD (4)
  ) dut (
    .clock           (kernel_monitor_clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block)
  );

  initial kernel_monitor_clock = 1'b0;
  always #5 kernel_monitor_clock = ~kernel_monitor_clock;

  task automatic chk(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge kernel_monitor_clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    axis_block_sigs = '0;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;
    tick();
    chk("reset_clear", block, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // Reset held with all streams stalled.
    reset = 1'b1;
    axis_block_sigs = 3'b111;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;
    #1;
    chk("rst_t0", block, 1'b0);
    tick();
    chk("rst_e1", block, 1'b0);
    tick();
    chk("rst_e2", block, 1'b0);
    reset = 1'b0;
    tick(); chk("rel_e1", block, 1'b0);
    tick(); chk("rel_e2", block, 1'b0);
    tick(); chk("rel_e3", block, 1'b0);
    tick(); chk("rel_e4", block, 1'b1);
    tick(); chk("rel_sat", block, 1'b1);
    axis_block_sigs = '0;
    tick(); chk("rel_drop", block, STICKY);
    // Re-assert block, then reset asynchronously mid-cycle.
    axis_block_sigs = 3'b111;
    for (int i = 0; i < 4; i++) tick();
    chk("async_pre", block, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst", block, 1'b0);
    #1;
    reset = 1'b0;
    axis_block_sigs = '0;

    // Three stalled cycles are one short of the threshold.
    do_reset();
    axis_block_sigs = 3'b010;
    tick(); chk("thr3_e1", block, 1'b0);
    tick(); chk("thr3_e2", block, 1'b0);
    tick(); chk("thr3_e3", block, 1'b0);
    axis_block_sigs = '0;
    tick(); chk("thr3_clr", block, 1'b0);
    axis_block_sigs = 3'b010;
    tick(); chk("thr4_e1", block, 1'b0);
    tick(); chk("thr4_e2", block, 1'b0);
    tick(); chk("thr4_e3", block, 1'b0);
    tick(); chk("thr4_e4", block, 1'b1);
    axis_block_sigs = '0;
    tick(); chk("thr4_rel1", block, STICKY);
    tick(); chk("thr4_rel2", block, STICKY);

    // Blocked-but-idle instance is masked.
    do_reset();
    inst_block_sigs = 1'b1;
    inst_idle_sigs  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_mask", block, 1'b0);
    end
    inst_idle_sigs = 1'b0;
    tick(); chk("inst_e1", block, 1'b0);
    tick(); chk("inst_e2", block, 1'b0);
    tick(); chk("inst_e3", block, 1'b0);
    tick(); chk("inst_e4", block, 1'b1);

    // Alternating blocked / idle never accumulates.
    do_reset();
    inst_block_sigs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst_idle_sigs = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      chk("idle_alt", block, 1'b0);
    end

    // A single clear cycle restarts the count.
    do_reset();
    axis_block_sigs = 3'b001;
    for (int i = 0; i < 3; i++) begin tick(); chk("gap_a", block, 1'b0); end
    axis_block_sigs = '0;
    tick(); chk("gap_clr", block, 1'b0);
    axis_block_sigs = 3'b001;
    for (int i = 0; i < 3; i++) begin tick(); chk("gap_b", block, 1'b0); end
    tick(); chk("gap_b4", block, 1'b1);

    // Hand-off between sources keeps the stall continuous.
    do_reset();
    axis_block_sigs = 3'b001;
    tick(); chk("hand_e1", block, 1'b0);
    tick(); chk("hand_e2", block, 1'b0);
    axis_block_sigs = 3'b100;
    tick(); chk("hand_e3", block, 1'b0);
    tick(); chk("hand_e4", block, 1'b1);
    // All sources together for long enough to expose a counter wrap.
    axis_block_sigs = 3'b111;
    inst_block_sigs = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); chk("multi_sat", block, 1'b1); end

    // Inputs cleared for 20 cycles.
    axis_block_sigs = '0;
    inst_block_sigs = '0;
    for (int i = 0; i < 20; i++) begin tick(); chk("clear_hold", block, STICKY); end
    #3;
    reset = 1'b1;
    #1;
    chk("sticky_rst", block, 1'b0);
    tick();
    reset = 1'b0;
    tick(); chk("post_rst", block, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/deadlock_idx0_monitor.md
# deadlock_idx0_monitor

Per-kernel deadlock detector for simulation and debug builds. It watches the per-port AXI-Stream stall indicators and the per-sub-instance block/idle indicators of one kernel. It asserts `block` once the kernel has been continuously stalled for a programmable number of cycles. It sits under the kernel-level deadlock monitor top, which prints diagnosis reports when `block` rises.

## Interface
- `N_AXIS`, default 3: number of AXI-Stream ports monitored (min 1).
- `N_INST`, default 1: number of sub-instances monitored (min 1).
- `BLOCK_THRESHOLD`, default 4: consecutive stalled cycles before `block` asserts (min 1).

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `axis_block_sigs`  in  N_AXIS: bit i = 1 means stream port i is stalled (input has no data, or output is not ready).
- `inst_idle_sigs`  in  N_INST: bit j = 1 means sub-instance j is idle.
- `inst_block_sigs`  in  N_INST: bit j = 1 means sub-instance j is blocked.
- `block`  out  1: registered kernel-blocked flag.

## Operation
- Combinational stall term: `stall_now = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs))`.
  - A blocked instance that is also idle does not count.
- Persistence counter `cnt` (width `$clog2(BLOCK_THRESHOLD+1)`):
  - `cnt_next = stall_now ? min(cnt+1, BLOCK_THRESHOLD) : 0`.
  - The counter saturates at `BLOCK_THRESHOLD` and never wraps.
- `block` is registered: `block <= (cnt_next == BLOCK_THRESHOLD)`.
- Non-sticky by default: `block` deasserts on the first edge where `stall_now` is 0.
- Inputs are sampled as-is. There is no input synchronisation and no glitch filtering beyond the counter.

## Timing
- Reset: `cnt = 0`, `block = 0`. Asserting reset clears both immediately, mid-count or while `block` is high.
- Latency: `stall_now` goes high before edge 1 and stays high. `cnt` reaches `BLOCK_THRESHOLD` at edge `BLOCK_THRESHOLD`, and `block` is high after that same edge.
- A one-cycle drop of `stall_now` at any point restarts the count from 0.
  - Blocked then idle cycles do not accumulate.
- Several stall sources at once behave the same as a single source.
  - Sources swapping on consecutive cycles keep `stall_now` continuously high, so the count continues.
- First edge after reset release: normal counting.

## Configuration
- `DEADLOCK_MONITOR_STICKY_EN` defined: once `block` asserts, it stays 1 until `reset`, whatever `stall_now` does afterwards. The counter keeps running but is ignored.
- Macro undefined: non-sticky behaviour as described above.

## Structure
- Shared package `deadlock_monitor_pkg`:
  - default constants `DFLT_N_AXIS = 3`, `DFLT_N_INST = 1`, `DFLT_BLOCK_THRESHOLD = 4`.
  - a function returning the counter width for a given threshold.
- Sub-module `stall_persistence_counter`:
  - parameter `THRESHOLD`.
  - inputs `clock`, `reset`, `stall`; output `hit`, which is `cnt_next == THRESHOLD`.
- Top of the block reduces the input vectors to `stall_now`, instantiates the sub-module, and holds the `block` register plus the sticky logic.

## Test plan
- Reset:
  - Apply reset with `axis_block_sigs = 3'b111`.
  - Require `block = 0` during reset.
  - After release, `block = 1` after edge 4 following release.
- Threshold:
  - `axis_block_sigs = 3'b010` held for 3 cycles, then 0: `block` never rises.
  - Held for 4 cycles: `block = 1` on the 4th edge, then 0 one edge after release (non-sticky build).
- Idle masking:
  - `inst_block_sigs = 1`, `inst_idle_sigs = 1`, axis bits 0 for 10 cycles: `block` stays 0.
  - Then set `inst_idle_sigs = 0`: `block = 1` 4 edges later.
- Gap restart: stall 3 cycles, 1 clear cycle, stall 3 cycles: `block` stays 0.
- Source hand-off: stall bit 0 for 2 cycles, then bit 2 for 2 cycles with no gap: `block = 1` at edge 4.
- Sticky build (`DEADLOCK_MONITOR_STICKY_EN` defined):
  - After `block` asserts, clear all inputs for 20 cycles: `block` stays 1.
  - Asynchronous reset pulse mid-cycle: `block` drops to 0 immediately.
